// File: rtl/h264dezigzag_buffer.sv
// Collects 16 zigzag-ordered dequantised coefficients into a ping-pong raster buffer
// with optional DC substitution, then presents each 4x4 block as four rows on valid/ready.
module h264dezigzag_buffer #(
    parameter int unsigned WIDTH   = 16,
    parameter logic        DCSUBST = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 VALID,
    input  logic                 DCCI,
    input  logic [WIDTH-1:0]     WIN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [4*WIDTH-1:0]   OUT_ROW,
    output logic [1:0]           OUT_ROWIDX,
    output logic                 OUT_LAST,
    output logic                 OVERFLOW
);

    localparam int unsigned SLOTS = 16;

    // Zigzag scan index to raster slot (4*row + col)
    function automatic logic [3:0] scan_to_raster(input logic [3:0] k);
        logic [3:0] r;
        case (k)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd1;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd8;
            4'd4:    r = 4'd5;
            4'd5:    r = 4'd2;
            4'd6:    r = 4'd3;
            4'd7:    r = 4'd6;
            4'd8:    r = 4'd9;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd13;
            4'd11:   r = 4'd10;
            4'd12:   r = 4'd7;
            4'd13:   r = 4'd11;
            4'd14:   r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0]   mem_q [2][SLOTS];

    logic [1:0]         full_q, full_d;
    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic [3:0]         scan_q, scan_d;
    logic [1:0]         row_q, row_d;
    logic               dc_pending_q, dc_pending_d;
    logic [WIDTH-1:0]   dc_hold_q, dc_hold_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [4*WIDTH-1:0] out_row_q, out_row_d;
    logic [1:0]         out_rowidx_q, out_rowidx_d;
    logic               out_last_q, out_last_d;

    logic               xfer;
    logic               bank_done;
    logic [1:0]         full_rd;
    logic               coef_we;
    logic [3:0]         wr_slot;
    logic [WIDTH-1:0]   wr_data;

    always_comb begin
        full_d       = full_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        scan_d       = scan_q;
        row_d        = row_q;
        dc_pending_d = dc_pending_q;
        dc_hold_d    = dc_hold_q;
        overflow_d   = overflow_q;
        coef_we      = 1'b0;
        wr_slot      = scan_to_raster(scan_q);
        wr_data      = WIN;

        xfer      = out_valid_q & OUT_READY;
        bank_done = xfer && (row_q == 2'd3);

        if (xfer) begin
            row_d = row_q + 2'd1;
        end
        full_rd = full_q;
        if (bank_done) begin
            full_d[rbank_q]  = 1'b0;
            full_rd[rbank_q] = 1'b0;
            rbank_d          = ~rbank_q;
        end

        // Full status is taken from before the edge, so a bank freed this cycle is not yet writable
        if (VALID) begin
            if (DCCI) begin
                if (DCSUBST) begin
                    dc_hold_d    = WIN;
                    dc_pending_d = 1'b1;
                end
            end else if (full_q[wbank_q]) begin
                overflow_d = 1'b1;
            end else begin
                coef_we = 1'b1;
                if (scan_q == 4'd0) begin
                    full_d[wbank_q] = 1'b1;
                    wbank_d         = ~wbank_q;
                    scan_d          = 4'd15;
                    if (DCSUBST && dc_pending_q) begin
                        wr_data      = dc_hold_q;
                        dc_pending_d = 1'b0;
                    end
                end else begin
                    scan_d = scan_q - 4'd1;
                end
            end
        end

        // A newly completed bank only becomes visible one edge after its full flag registers
        out_valid_d  = full_rd[rbank_d];
        out_rowidx_d = out_valid_d ? row_d : 2'd0;
        out_last_d   = out_valid_d && (row_d == 2'd3);
        out_row_d    = '0;
        if (out_valid_d) begin
            out_row_d = {mem_q[rbank_d][{row_d, 2'd3}], mem_q[rbank_d][{row_d, 2'd2}],
                         mem_q[rbank_d][{row_d, 2'd1}], mem_q[rbank_d][{row_d, 2'd0}]};
        end
    end

    always_ff @(posedge CLK) begin
        if (coef_we) begin
            mem_q[wbank_q][wr_slot] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            full_q       <= 2'b00;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            scan_q       <= 4'd15;
            row_q        <= 2'd0;
            dc_pending_q <= 1'b0;
            dc_hold_q    <= '0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_row_q    <= '0;
            out_rowidx_q <= 2'd0;
            out_last_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            scan_q       <= scan_d;
            row_q        <= row_d;
            dc_pending_q <= dc_pending_d;
            dc_hold_q    <= dc_hold_d;
            overflow_q   <= overflow_d;
            out_valid_q  <= out_valid_d;
            out_row_q    <= out_row_d;
            out_rowidx_q <= out_rowidx_d;
            out_last_q   <= out_last_d;
        end
    end

    assign OUT_VALID  = out_valid_q;
    assign OUT_ROW    = out_row_q;
    assign OUT_ROWIDX = out_rowidx_q;
    assign OUT_LAST   = out_last_q;
    assign OVERFLOW   = overflow_q;

endmodule

// File: doc/h264dezigzag_buffer.md
Name: h264dezigzag_buffer

Overview:
- Stage directly downstream of the H.264 dequantiser and upstream of the 4x4 inverse transform.
- Collects the 16 dequantised coefficients of a 4x4 block, which arrive in descending zigzag scan order (scan index 15 first, 0 last). Reorders them into raster order in a ping-pong buffer.
- Optionally substitutes a separately delivered DC coefficient at raster position (0,0).
- Presents the block as four 4-coefficient rows on a valid/ready handshake.

Parameters:
- WIDTH, 16, coefficient width in bits.
- DCSUBST, 1'b1, 1 = a DCCI-tagged word replaces raster (0,0) of the next completed block; 0 = DCCI words are discarded.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous active-high reset.
- VALID  in  1  input coefficient strobe, from the dequantiser VALID.
- DCCI  in  1  qualifies VALID; the word is a DC coefficient, from the dequantiser DCCO.
- WIN  in  WIDTH  coefficient, from the dequantiser WOUT.
- OUT_VALID  out  1  row available.
- OUT_READY  in  1  downstream accepts row.
- OUT_ROW  out  4*WIDTH  row {c3,c2,c1,c0}; c0 in bits [WIDTH-1:0] is column 0.
- OUT_ROWIDX  out  2  row number 0..3.
- OUT_LAST  out  1  high with row 3.
- OVERFLOW  out  1  sticky: a coefficient was dropped because both banks were full.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - All outputs go to 0.
  - Both banks marked empty; write bank = 0, read bank = 0.
  - Scan counter = 15, row counter = 0, dc_pending = 0.
  - Reset mid-block or mid-readout discards all buffered data.
- Scan map, scan index k -> raster index r = 4*row + col:
  0->0, 1->1, 2->4, 3->8, 4->5, 5->2, 6->3, 7->6, 8->9, 9->12, 10->13, 11->10, 12->7, 13->11, 14->14, 15->15.
- Write side:
  - VALID=1, DCCI=0, write bank not full: WIN is stored at the raster slot of the current scan index, then the scan counter decrements.
  - When the word at k=0 is written:
    - Bank marked full; scan counter reloads to 15; write bank toggles.
    - If DCSUBST=1 and dc_pending=1, slot 0 is written with dc_hold instead of WIN, and dc_pending clears.
  - VALID=1, DCCI=1:
    - DCSUBST=1: WIN goes to dc_hold and dc_pending sets. A second DC word before block completion overwrites the first.
    - DCSUBST=0: the word is ignored.
    - The scan counter never changes on a DC word.
  - VALID=1, DCCI=0, write bank full (both banks full): word dropped, OVERFLOW=1 until reset, scan counter unchanged.
- Read side:
  - OUT_VALID=1 whenever the read bank is full.
  - OUT_ROW holds raster slots 4*row .. 4*row+3 of the read bank; OUT_ROWIDX = row counter; OUT_LAST = (row counter == 3).
  - A transfer occurs when OUT_VALID and OUT_READY are both 1. On a transfer the row counter increments.
  - On the transfer of row 3: read bank marked empty, read bank toggles, row counter returns to 0.
  - OUT_ROW, OUT_ROWIDX and OUT_LAST stay stable while OUT_VALID=1 and OUT_READY=0.
- Latency and throughput:
  - The k=0 word is written at edge N; OUT_VALID=1 after edge N+1 (registered full flag).
  - Sustained throughput: 1 coefficient/cycle in, 1 row/cycle out. With OUT_READY held high there is no overflow at 16 coefficients per 16 cycles.
- Simultaneous events:
  - Readout releasing a bank and a write to the other bank in the same cycle are both honoured.
  - When the read side frees the bank in the same cycle that the write side finds both banks full, the word is still dropped. Full status is evaluated before the edge.
- Arithmetic: none. Coefficients pass bit-exact; no clipping or sign change.

Test Plan:
- Reset, then WIN = 100+k for scan indices 15..0 on consecutive VALID cycles, OUT_READY=1 -> OUT_VALID one cycle after the last write. Rows:
  - row0 {106,105,101,100}
  - row1 {112,107,104,102}
  - row2 {113,111,108,103}
  - row3 {115,114,110,109}, with OUT_LAST=1.
- DC word 0x0ABC with DCCI=1, then 16 words of 0x0001 -> row0 c0 = 0x0ABC, all other coefficients 0x0001, dc_pending cleared. The next block has c0 = 0x0001.
- Backpressure:
  - Three blocks back-to-back with OUT_READY=0 -> blocks 1 and 2 buffered, all 16 words of block 3 dropped, OVERFLOW=1.
  - Then OUT_READY=1 -> blocks 1 and 2 output intact, in order.
- OUT_READY toggling 1,0,1,0 during readout -> each row held stable while stalled; exactly 4 transfers per block, OUT_ROWIDX sequence 0,1,2,3.
- RESET asserted after 7 words of a block -> all outputs 0. A following clean 16-word block is reordered correctly with no residue from the aborted block.
- DCSUBST=0 instance: DC word 0x7FFF then 16 words of 0x0002 -> all 16 output coefficients 0x0002.
